// File: rtl/des_ahb_master.sv
// des_ahb_master: AHB-Lite single-transfer master that runs one Triple-DES
// operation on the slave: write KEY1..KEY3, DATA and CTRL, poll STATUS until
// done, read RESULT, and hand it back to the host with a one-cycle strobe.
// Transfers are strictly non-pipelined: one address-phase cycle (NONSEQ),
// then a data phase (IDLE) that stretches while HREADY is low.
// Optional feature macro: DES_KEY_CACHE_EN -- when defined, the keys of the
// last successfully completed operation are remembered and an operation
// with identical keys starts directly at the DATA write.
module des_ahb_master #(
  parameter int unsigned POLL_LIMIT = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        encrypt,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic [63:0] data_in,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [15:0] POLL_LIMIT_C  = 16'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_KEY1 = 4'd1,
    S_W_KEY2 = 4'd2,
    S_W_KEY3 = 4'd3,
    S_W_DATA = 4'd4,
    S_W_CTRL = 4'd5,
    S_R_STAT = 4'd6,
    S_R_RES  = 4'd7,
    S_DONE   = 4'd8
  } state_e;

  state_e      state_q;
  logic        phase_q;          // 1'b0 address phase, 1'b1 data phase
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [1:0]  htrans_q;
  logic [63:0] hwdata_q;
  logic [63:0] k1_q, k2_q, k3_q, data_q;
  logic        enc_q;
  logic [15:0] poll_q;
  logic [63:0] result_q;
  logic        result_valid_q;
  logic        busy_q;
  logic        error_q;

  logic [63:0] wdata_s;
  logic        cache_hit_s;
  state_e      first_state_s;
  logic        complete_s;
  logic        timeout_s;
  logic        op_ok_s;
  logic        op_err_s;

  // Slave register address for each bus state.
  function automatic logic [31:0] addr_of(input state_e s);
    case (s)
      S_W_KEY1: addr_of = BASE_ADDR + 32'h0000_0000;
      S_W_KEY2: addr_of = BASE_ADDR + 32'h0000_0008;
      S_W_KEY3: addr_of = BASE_ADDR + 32'h0000_0010;
      S_W_DATA: addr_of = BASE_ADDR + 32'h0000_0018;
      S_W_CTRL: addr_of = BASE_ADDR + 32'h0000_0020;
      S_R_STAT: addr_of = BASE_ADDR + 32'h0000_0028;
      S_R_RES:  addr_of = BASE_ADDR + 32'h0000_0030;
      default:  addr_of = BASE_ADDR;
    endcase
  endfunction

  // Successor of a write state once its transfer completes.
  function automatic state_e next_of(input state_e s);
    case (s)
      S_W_KEY1: next_of = S_W_KEY2;
      S_W_KEY2: next_of = S_W_KEY3;
      S_W_KEY3: next_of = S_W_DATA;
      S_W_DATA: next_of = S_W_CTRL;
      S_W_CTRL: next_of = S_R_STAT;
      default:  next_of = S_IDLE;
    endcase
  endfunction

  assign complete_s = (state_q != S_IDLE) && (state_q != S_DONE) && phase_q && HREADY;
  assign timeout_s  = (state_q == S_R_STAT) && !HRDATA[0] && ((poll_q + 16'd1) >= POLL_LIMIT_C);
  assign op_ok_s    = complete_s && !HRESP && (state_q == S_R_RES);
  assign op_err_s   = complete_s && (HRESP || timeout_s);
  assign first_state_s = cache_hit_s ? S_W_DATA : S_W_KEY1;

`ifdef DES_KEY_CACHE_EN
  logic [63:0] ck1_q, ck2_q, ck3_q;
  logic        cache_vld_q;

  assign cache_hit_s = cache_vld_q && (key1 == ck1_q) && (key2 == ck2_q) && (key3 == ck3_q);

  // Key cache: filled by a successful result read, dropped on any error.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      ck1_q       <= 64'd0;
      ck2_q       <= 64'd0;
      ck3_q       <= 64'd0;
      cache_vld_q <= 1'b0;
    end else if (op_err_s) begin
      cache_vld_q <= 1'b0;
    end else if (op_ok_s) begin
      ck1_q       <= k1_q;
      ck2_q       <= k2_q;
      ck3_q       <= k3_q;
      cache_vld_q <= 1'b1;
    end
  end
`else
  assign cache_hit_s = 1'b0;
`endif

  // Write data for the current bus state, taken from the latched operands.
  always_comb begin
    wdata_s = 64'd0;
    case (state_q)
      S_W_KEY1: wdata_s = k1_q;
      S_W_KEY2: wdata_s = k2_q;
      S_W_KEY3: wdata_s = k3_q;
      S_W_DATA: wdata_s = data_q;
      S_W_CTRL: wdata_s = {62'd0, enc_q, 1'b1};
      default:  wdata_s = 64'd0;
    endcase
  end

  // Operation sequencer: accepts start, walks the transfer list, handles errors.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q        <= S_IDLE;
      phase_q        <= 1'b0;
      haddr_q        <= 32'd0;
      hwrite_q       <= 1'b0;
      htrans_q       <= HTRANS_IDLE;
      hwdata_q       <= 64'd0;
      k1_q           <= 64'd0;
      k2_q           <= 64'd0;
      k3_q           <= 64'd0;
      data_q         <= 64'd0;
      enc_q          <= 1'b0;
      poll_q         <= 16'd0;
      result_q       <= 64'd0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start coinciding with the error strobe is dropped.
          if (start && !error_q) begin
            k1_q     <= key1;
            k2_q     <= key2;
            k3_q     <= key3;
            data_q   <= data_in;
            enc_q    <= encrypt;
            poll_q   <= 16'd0;
            busy_q   <= 1'b1;
            state_q  <= first_state_s;
            phase_q  <= 1'b0;
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= addr_of(first_state_s);
            hwrite_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          if (!phase_q) begin
            phase_q  <= 1'b1;
            htrans_q <= HTRANS_IDLE;
            if (hwrite_q) begin
              hwdata_q <= wdata_s;
            end
          end else if (HREADY) begin
            if (op_err_s) begin
              if (!HRESP) begin
                poll_q <= poll_q + 16'd1;
              end
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
              error_q  <= 1'b1;
              hwrite_q <= 1'b0;
            end else if (state_q == S_R_STAT) begin
              phase_q  <= 1'b0;
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= 1'b0;
              if (HRDATA[0]) begin
                state_q <= S_R_RES;
                haddr_q <= addr_of(S_R_RES);
              end else begin
                poll_q  <= poll_q + 16'd1;
                haddr_q <= addr_of(S_R_STAT);
              end
            end else if (state_q == S_R_RES) begin
              result_q       <= HRDATA;
              result_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              state_q  <= next_of(state_q);
              phase_q  <= 1'b0;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= addr_of(next_of(state_q));
              hwrite_q <= (next_of(state_q) != S_R_STAT);
            end
          end
        end
      endcase
    end
  end

  assign HADDR        = haddr_q;
  assign HWRITE       = hwrite_q;
  assign HTRANS       = htrans_q;
  assign HWDATA       = hwdata_q;
  assign HSIZE        = 3'b011;
  assign HBURST       = 3'b000;
  assign HPROT        = 4'b0011;
  assign HMASTLOCK    = 1'b0;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule

// File: tb/tb_des_ahb_master.sv
// tb_des_ahb_master: directed bench for des_ahb_master with a small AHB slave
// model that logs every completed transfer. Two instances are built: the
// default one (POLL_LIMIT=64) and one with POLL_LIMIT=4 for the timeout case.
module tb_des_ahb_master;

  localparam logic [31:0] A_KEY1 = 32'h00;
  localparam logic [31:0] A_KEY2 = 32'h08;
  localparam logic [31:0] A_KEY3 = 32'h10;
  localparam logic [31:0] A_DATA = 32'h18;
  localparam logic [31:0] A_CTRL = 32'h20;
  localparam logic [31:0] A_STAT = 32'h28;
  localparam logic [31:0] A_RES  = 32'h30;
  localparam logic [31:0] A_NONE = 32'hFFFF_FFFF;
  localparam logic [31:0] SEQ_ADDR [7] = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30};

  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h23456789ABCDEF01;
  localparam logic [63:0] K3 = 64'h456789ABCDEF0123;
  localparam logic [63:0] D1 = 64'h4E6F772069732074;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start, encrypt;
  logic [63:0] key1, key2, key3, data_in;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;
  logic [63:0] HRDATA = 64'd0;
  logic        sel;

  logic [31:0] a_haddr, b_haddr;
  logic        a_hwrite, b_hwrite, a_hml, b_hml;
  logic [1:0]  a_htrans, b_htrans;
  logic [2:0]  a_hsize, b_hsize, a_hburst, b_hburst;
  logic [3:0]  a_hprot, b_hprot;
  logic [63:0] a_hwdata, b_hwdata, a_result, b_result;
  logic        a_rv, b_rv, a_busy, b_busy, a_err, b_err;

  logic        start_a, start_b;
  logic [31:0] m_haddr;
  logic        m_hwrite, m_rv, m_busy, m_err;
  logic [1:0]  m_htrans;
  logic [63:0] m_hwdata, m_result;

  assign start_a  = start & ~sel;
  assign start_b  = start & sel;
  assign m_haddr  = sel ? b_haddr  : a_haddr;
  assign m_hwrite = sel ? b_hwrite : a_hwrite;
  assign m_htrans = sel ? b_htrans : a_htrans;
  assign m_hwdata = sel ? b_hwdata : a_hwdata;
  assign m_result = sel ? b_result : a_result;
  assign m_rv     = sel ? b_rv     : a_rv;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_err    = sel ? b_err    : a_err;

  des_ahb_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_a), .encrypt(encrypt),
    .key1(key1), .key2(key2), .key3(key3), .data_in(data_in),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(a_haddr), .HWRITE(a_hwrite), .HTRANS(a_htrans), .HSIZE(a_hsize),
    .HBURST(a_hburst), .HPROT(a_hprot), .HMASTLOCK(a_hml), .HWDATA(a_hwdata),
    .result(a_result), .result_valid(a_rv), .busy(a_busy), .error(a_err)
  );

  des_ahb_master #(.POLL_LIMIT(4)) dut_p4 (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_b), .encrypt(encrypt),
    .key1(key1), .key2(key2), .key3(key3), .data_in(data_in),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .HADDR(b_haddr), .HWRITE(b_hwrite), .HTRANS(b_htrans), .HSIZE(b_hsize),
    .HBURST(b_hburst), .HPROT(b_hprot), .HMASTLOCK(b_hml), .HWDATA(b_hwdata),
    .result(b_result), .result_valid(b_rv), .busy(b_busy), .error(b_err)
  );

  always #5 HCLK = ~HCLK;

  int vec  = 0;
  int miss = 0;

  // slave model configuration and transfer log
  logic [31:0] err_addr  = A_NONE;
  logic [31:0] wait_addr = A_NONE;
  int          wait_n    = 0;
  int          done_after = 0;
  logic [63:0] res_val   = 64'd0;
  int          stat_reads = 0;
  int          wait_seen = 0;
  int          wait_bad  = 0;
  logic [31:0] lg_addr [$];
  logic        lg_wr   [$];
  logic [63:0] lg_wd   [$];

  logic        dp = 1'b0;
  logic        first_dp = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  logic        cur_wr = 1'b0;
  logic [63:0] hold_ref = 64'd0;
  int          wcnt = 0;

  // AHB slave model: acts on the falling edge, so the master samples its
  // response on the following rising edge.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      dp = 1'b0; wcnt = 0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 64'd0;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp) begin
        if (m_htrans !== 2'b00) wait_bad++;
        if (cur_wr) begin
          if (first_dp) hold_ref = m_hwdata;
          else if (m_hwdata !== hold_ref) wait_bad++;
        end
        first_dp = 1'b0;
        if (wcnt > 0) begin
          HREADY = 1'b0; wcnt--; wait_seen++;
        end else begin
          HRESP = (cur_addr == err_addr);
          if (!cur_wr) begin
            if (cur_addr == A_STAT) begin
              HRDATA = {63'd0, stat_reads >= done_after};
              stat_reads++;
            end else if (cur_addr == A_RES) HRDATA = res_val;
            else HRDATA = 64'd0;
          end
          lg_addr.push_back(cur_addr);
          lg_wr.push_back(cur_wr);
          lg_wd.push_back(m_hwdata);
          dp = 1'b0;
        end
      end
      if (m_htrans == 2'b10) begin
        cur_addr = m_haddr; cur_wr = m_hwrite; dp = 1'b1; first_dp = 1'b1;
        wcnt = (m_haddr == wait_addr) ? wait_n : 0;
      end
    end
  end

  // One operation: start held for one cycle, then wait (bounded) for
  // result_valid or error. lat is the cycle of the strobe, start cycle = 0.
  task automatic run_op(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                        input logic [63:0] d, input logic enc,
                        output int lat, output logic got_rv, output logic got_err);
    lg_addr.delete(); lg_wr.delete(); lg_wd.delete();
    stat_reads = 0;
    @(posedge HCLK); #1;
    key1 = k1; key2 = k2; key3 = k3; data_in = d; encrypt = enc; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    lat = 1; got_rv = 1'b0; got_err = 1'b0;
    while (lat < 400) begin
      if (m_rv) begin got_rv = 1'b1; break; end
      if (m_err) begin got_err = 1'b1; break; end
      @(posedge HCLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b0; start = 1'b0; encrypt = 1'b0; sel = 1'b0;
    key1 = 64'd0; key2 = 64'd0; key3 = 64'd0; data_in = 64'd0;
    repeat (2) @(posedge HCLK);
    #1;
    vec++; if (m_htrans !== 2'b00) begin miss++; $display("FAIL rst_htrans: got %b expected 00", m_htrans); end
    vec++; if (m_haddr !== 32'd0) begin miss++; $display("FAIL rst_haddr: got %h expected 0", m_haddr); end
    vec++; if (m_hwrite !== 1'b0) begin miss++; $display("FAIL rst_hwrite: got %b expected 0", m_hwrite); end
    vec++; if (m_hwdata !== 64'd0) begin miss++; $display("FAIL rst_hwdata: got %h expected 0", m_hwdata); end
    vec++; if (m_result !== 64'd0) begin miss++; $display("FAIL rst_result: got %h expected 0", m_result); end
    vec++; if ({m_rv, m_busy, m_err} !== 3'b000) begin miss++; $display("FAIL rst_flags: got %b expected 000", {m_rv, m_busy, m_err}); end
    vec++; if ({a_hsize, a_hburst, a_hprot, a_hml} !== {3'b011, 3'b000, 4'b0011, 1'b0}) begin
      miss++; $display("FAIL const_ctrl: got %b_%b_%b_%b expected 011_000_0011_0", a_hsize, a_hburst, a_hprot, a_hml);
    end
    @(negedge HCLK);
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    vec++; if ({m_htrans, m_busy} !== 3'b000) begin miss++; $display("FAIL idle_after_rst: got %b expected 000", {m_htrans, m_busy}); end
  endtask

  task automatic test_encrypt;
    int lat; logic rv, er;
    logic [63:0] ewd [5];
    ewd = '{K1, K2, K3, D1, 64'h3};
    done_after = 0; res_val = 64'hA1B2C3D4E5F60718;
    run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
    vec++; if (rv !== 1'b1 || er !== 1'b0) begin miss++; $display("FAIL enc_strobe: got rv=%b err=%b expected rv=1 err=0", rv, er); end
    vec++; if (lat != 15) begin miss++; $display("FAIL enc_latency: got %0d expected 15", lat); end
    vec++; if (m_result !== 64'hA1B2C3D4E5F60718) begin miss++; $display("FAIL enc_result: got %h expected a1b2c3d4e5f60718", m_result); end
    vec++; if (m_busy !== 1'b1) begin miss++; $display("FAIL enc_busy_done: got %b expected 1", m_busy); end
    vec++; if (lg_addr.size() != 7) begin miss++; $display("FAIL enc_count: got %0d expected 7", lg_addr.size()); end
    for (int i = 0; i < 7; i++) begin
      if (i < lg_addr.size()) begin
        vec++;
        if (lg_addr[i] !== SEQ_ADDR[i] || lg_wr[i] !== (i < 5)) begin
          miss++; $display("FAIL enc_xfer%0d: got addr %h wr %b expected addr %h wr %b", i, lg_addr[i], lg_wr[i], SEQ_ADDR[i], (i < 5));
        end
        if (i < 5) begin
          vec++;
          if (lg_wd[i] !== ewd[i]) begin miss++; $display("FAIL enc_wdata%0d: got %h expected %h", i, lg_wd[i], ewd[i]); end
        end
      end
    end
    @(posedge HCLK); #1;
    vec++; if ({m_rv, m_busy} !== 2'b00) begin miss++; $display("FAIL enc_after: got rv/busy %b expected 00", {m_rv, m_busy}); end
    vec++; if (m_result !== 64'hA1B2C3D4E5F60718) begin miss++; $display("FAIL enc_held: got %h expected a1b2c3d4e5f60718", m_result); end
  endtask

  task automatic test_decrypt;
    int lat; logic rv, er;
    res_val = 64'h0F1E2D3C4B5A6978;
    run_op(64'h1111, 64'h2222, 64'h3333, 64'hDEAD_BEEF, 1'b0, lat, rv, er);
    vec++; if (rv !== 1'b1 || lat != 15) begin miss++; $display("FAIL dec_done: got rv=%b lat=%0d expected rv=1 lat=15", rv, lat); end
    vec++; if (lg_addr.size() != 7) begin miss++; $display("FAIL dec_count: got %0d expected 7", lg_addr.size()); end
    else begin
      vec++; if (lg_wd[4] !== 64'h1) begin miss++; $display("FAIL dec_ctrl: got %h expected 1", lg_wd[4]); end
      vec++; if (lg_wd[0] !== 64'h1111 || lg_wd[3] !== 64'hDEAD_BEEF) begin
        miss++; $display("FAIL dec_wdata: got %h/%h expected 1111/deadbeef", lg_wd[0], lg_wd[3]);
      end
    end
    vec++; if (m_result !== 64'h0F1E2D3C4B5A6978) begin miss++; $display("FAIL dec_result: got %h expected 0f1e2d3c4b5a6978", m_result); end
  endtask

  task automatic test_wait_states;
    int lat; logic rv, er;
    wait_addr = A_DATA; wait_n = 3; wait_seen = 0; wait_bad = 0;
    res_val = 64'h5555_AAAA_5555_AAAA;
    run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
    wait_addr = A_NONE; wait_n = 0;
    vec++; if (rv !== 1'b1 || lat != 18) begin miss++; $display("FAIL wait_latency: got rv=%b lat=%0d expected rv=1 lat=18", rv, lat); end
    vec++; if (wait_seen != 3) begin miss++; $display("FAIL wait_cycles: got %0d expected 3", wait_seen); end
    vec++; if (wait_bad != 0) begin miss++; $display("FAIL wait_hold: got %0d bad data-phase cycles expected 0", wait_bad); end
    vec++; if (lg_addr.size() != 7) begin miss++; $display("FAIL wait_count: got %0d expected 7", lg_addr.size()); end
    else begin
      vec++; if (lg_wd[3] !== D1) begin miss++; $display("FAIL wait_data: got %h expected %h", lg_wd[3], D1); end
    end
  endtask

  task automatic test_poll;
    int lat; logic rv, er; int ns;
    done_after = 5; res_val = 64'h0123_4567_89AB_CDEF;
    run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
    done_after = 0;
    ns = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == A_STAT) ns++;
    vec++; if (rv !== 1'b1 || lat != 25) begin miss++; $display("FAIL poll_latency: got rv=%b lat=%0d expected rv=1 lat=25", rv, lat); end
    vec++; if (ns != 6) begin miss++; $display("FAIL poll_reads: got %0d expected 6", ns); end
    vec++; if (lg_addr.size() != 12) begin miss++; $display("FAIL poll_count: got %0d expected 12", lg_addr.size()); end
    else begin
      vec++; if (lg_addr[11] !== A_RES) begin miss++; $display("FAIL poll_last: got %h expected 30", lg_addr[11]); end
    end
    vec++; if (m_result !== 64'h0123_4567_89AB_CDEF) begin miss++; $display("FAIL poll_result: got %h expected 0123456789abcdef", m_result); end
  endtask

  task automatic test_timeout;
    int lat; logic rv, er; int ns;
    sel = 1'b1; done_after = 1000;
    run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
    ns = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == A_STAT) ns++;
    vec++; if (er !== 1'b1 || rv !== 1'b0) begin miss++; $display("FAIL tmo_strobe: got err=%b rv=%b expected err=1 rv=0", er, rv); end
    vec++; if (lat != 19) begin miss++; $display("FAIL tmo_latency: got %0d expected 19", lat); end
    vec++; if (m_busy !== 1'b0) begin miss++; $display("FAIL tmo_busy: got %b expected 0", m_busy); end
    vec++; if (ns != 4 || lg_addr.size() != 9) begin miss++; $display("FAIL tmo_reads: got %0d status of %0d total expected 4 of 9", ns, lg_addr.size()); end
    repeat (4) @(posedge HCLK);
    #1;
    vec++; if (lg_addr.size() != 9) begin miss++; $display("FAIL tmo_no_result_read: got %0d transfers expected 9", lg_addr.size()); end
    sel = 1'b0; done_after = 0;
  endtask

  task automatic test_hresp;
    int lat; logic rv, er;
    err_addr = A_KEY2;
    run_op(64'h7777, 64'h8888, 64'h9999, 64'hAAAA, 1'b1, lat, rv, er);
    err_addr = A_NONE;
    vec++; if (er !== 1'b1 || rv !== 1'b0 || lat != 5) begin miss++; $display("FAIL resp_strobe: got err=%b rv=%b lat=%0d expected 1 0 5", er, rv, lat); end
    vec++; if (m_busy !== 1'b0) begin miss++; $display("FAIL resp_busy: got %b expected 0", m_busy); end
    vec++; if (m_result !== 64'h0123_4567_89AB_CDEF) begin miss++; $display("FAIL resp_result: got %h expected 0123456789abcdef", m_result); end
    // start in the same cycle as the error strobe must be ignored
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    repeat (8) @(posedge HCLK);
    #1;
    vec++; if (lg_addr.size() != 2) begin miss++; $display("FAIL resp_quiet: got %0d transfers expected 2", lg_addr.size()); end
    vec++; if ({m_htrans, m_busy} !== 3'b000) begin miss++; $display("FAIL resp_idle: got %b expected 000", {m_htrans, m_busy}); end
  endtask

  task automatic test_back_to_back;
    int lat; logic rv, er;
    res_val = 64'hCAFE_F00D_1234_5678;
    fork
      run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
      begin
        repeat (5) @(posedge HCLK);
        #2; start = 1'b1; data_in = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge HCLK);
        #2; start = 1'b0;
      end
    join
    vec++; if (rv !== 1'b1 || lat != 15) begin miss++; $display("FAIL busy_start_lat: got rv=%b lat=%0d expected rv=1 lat=15", rv, lat); end
    vec++; if (lg_addr.size() != 7) begin miss++; $display("FAIL busy_start_count: got %0d expected 7", lg_addr.size()); end
    else begin
      vec++; if (lg_wd[3] !== D1) begin miss++; $display("FAIL busy_start_data: got %h expected %h", lg_wd[3], D1); end
    end
    repeat (4) @(posedge HCLK);
    #1;
    vec++; if (lg_addr.size() != 7 || m_busy !== 1'b0) begin miss++; $display("FAIL busy_start_quiet: got %0d transfers busy=%b expected 7 0", lg_addr.size(), m_busy); end
  endtask

  task automatic test_reset_mid;
    int lat; logic rv, er; int n;
    wait_addr = A_CTRL; wait_n = 5;
    @(posedge HCLK); #1;
    key1 = K1; key2 = K2; key3 = K3; data_in = D1; encrypt = 1'b1; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    n = 0;
    while (!(m_htrans == 2'b10 && m_haddr == A_CTRL) && n < 50) begin
      @(posedge HCLK); #1; n++;
    end
    vec++; if (n >= 50) begin miss++; $display("FAIL mid_reach_ctrl: got timeout after %0d cycles expected CTRL address phase", n); end
    @(posedge HCLK);
    #3; HRESET = 1'b0;
    #1;
    vec++; if ({m_htrans, m_hwrite, m_busy, m_rv, m_err} !== 6'b0) begin
      miss++; $display("FAIL mid_rst_flags: got %b expected 000000", {m_htrans, m_hwrite, m_busy, m_rv, m_err});
    end
    vec++; if (m_haddr !== 32'd0 || m_hwdata !== 64'd0 || m_result !== 64'd0) begin
      miss++; $display("FAIL mid_rst_values: got %h/%h/%h expected 0/0/0", m_haddr, m_hwdata, m_result);
    end
    @(negedge HCLK); #1;
    HRESET = 1'b1;
    wait_addr = A_NONE; wait_n = 0;
    res_val = 64'h1357_9BDF_0246_8ACE;
    run_op(K1, K2, K3, D1, 1'b1, lat, rv, er);
    vec++; if (rv !== 1'b1 || lat != 15 || lg_addr.size() != 7) begin
      miss++; $display("FAIL mid_rerun: got rv=%b lat=%0d n=%0d expected rv=1 lat=15 n=7", rv, lat, lg_addr.size());
    end
    vec++; if (m_result !== 64'h1357_9BDF_0246_8ACE) begin miss++; $display("FAIL mid_rerun_result: got %h expected 13579bdf02468ace", m_result); end
  endtask

  task automatic test_key_cache;
    int lat; logic rv, er;
    res_val = 64'h2468_ACE0_1357_9BDF;
    run_op(64'hA1, 64'hA2, 64'hA3, 64'hD1, 1'b1, lat, rv, er);
    vec++; if (rv !== 1'b1 || lat != 15 || lg_addr.size() != 7) begin
      miss++; $display("FAIL cache_first: got rv=%b lat=%0d n=%0d expected 1 15 7", rv, lat, lg_addr.size());
    end
    run_op(64'hA1, 64'hA2, 64'hA3, 64'hD2, 1'b1, lat, rv, er);
`ifdef DES_KEY_CACHE_EN
    vec++; if (rv !== 1'b1 || lat != 9 || lg_addr.size() != 4) begin
      miss++; $display("FAIL cache_hit: got rv=%b lat=%0d n=%0d expected 1 9 4", rv, lat, lg_addr.size());
    end
    else begin
      vec++; if (lg_addr[0] !== A_DATA || lg_wd[0] !== 64'hD2) begin miss++; $display("FAIL cache_hit_first: got %h/%h expected 18/d2", lg_addr[0], lg_wd[0]); end
    end
`else
    vec++; if (rv !== 1'b1 || lat != 15 || lg_addr.size() != 7) begin
      miss++; $display("FAIL cache_off: got rv=%b lat=%0d n=%0d expected 1 15 7", rv, lat, lg_addr.size());
    end
`endif
    run_op(64'hA1, 64'hA2, 64'hB3, 64'hD3, 1'b1, lat, rv, er);
    vec++; if (rv !== 1'b1 || lat != 15 || lg_addr.size() != 7) begin
      miss++; $display("FAIL cache_miss: got rv=%b lat=%0d n=%0d expected 1 15 7", rv, lat, lg_addr.size());
    end
    else begin
      vec++; if (lg_wd[2] !== 64'hB3) begin miss++; $display("FAIL cache_miss_key3: got %h expected b3", lg_wd[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_wait_states();
    test_poll();
    test_timeout();
    test_hresp();
    test_back_to_back();
    test_reset_mid();
    test_key_cache();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
